// File: rtl/second_vector_vxv_reader.sv
// Snapshots the padded second-vector word on start and streams it to the VxV array
// as no_of_units-element chunks, element 0 of the vector in the most significant lane.
module second_vector_vxv_reader #(
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 32,
    parameter int no_of_units                     = 8,
    parameter int chunk_index_width               = 8,
    localparam int additional       = no_of_units - (number_of_equations_per_cluster % no_of_units),
    localparam int total            = number_of_equations_per_cluster + additional,
    localparam int number_of_chunks = total / no_of_units,
    localparam int WordWidth        = element_width * total,
    localparam int ChunkWidth       = element_width * no_of_units
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [WordWidth-1:0]         memory_output,
    input  logic                         chunk_ready,
    output logic [ChunkWidth-1:0]        chunk_data,
    output logic                         chunk_valid,
    output logic [chunk_index_width-1:0] chunk_index,
    output logic                         last_chunk,
    output logic                         busy,
    output logic                         done
);

    localparam logic [chunk_index_width-1:0] LastIndex = chunk_index_width'(number_of_chunks - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_e;

    state_e                         state_q, state_d;
    logic [WordWidth-1:0]           snapshot_q, snapshot_d;
    logic [chunk_index_width-1:0]   chunk_index_q, chunk_index_d;
    logic [WordWidth-1:0]           shifted_window;
    logic                           handshake;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            snapshot_q    <= '0;
            chunk_index_q <= '0;
        end else begin
            state_q       <= state_d;
            snapshot_q    <= snapshot_d;
            chunk_index_q <= chunk_index_d;
        end
    end

    assign handshake = chunk_valid & chunk_ready;

    always_comb begin
        state_d       = state_q;
        snapshot_d    = snapshot_q;
        chunk_index_d = chunk_index_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snapshot_d    = memory_output;
                    chunk_index_d = '0;
                    state_d       = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (chunk_index_q == LastIndex) begin
                        chunk_index_d = '0;
                        state_d       = FIN;
                    end else begin
                        chunk_index_d = chunk_index_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shifting the current chunk up to the MSB end keeps the slice position constant.
    assign shifted_window = snapshot_q << (ChunkWidth * chunk_index_q);

    assign chunk_valid = (state_q == STREAM);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign chunk_index = chunk_index_q;
    assign last_chunk  = chunk_valid & (chunk_index_q == LastIndex);
    assign chunk_data  = chunk_valid ? shifted_window[WordWidth-1 -: ChunkWidth] : '0;

endmodule

// File: tb/tb_second_vector_vxv_reader.sv
// Randomized bench for second_vector_vxv_reader: a vector-level model of elements and
// chunks is compared against the default (N=9) and the fully padded (N=8) instances.
module tb_second_vector_vxv_reader;

    localparam int W  = 32;
    localparam int U  = 8;
    localparam int TOT = 16;
    localparam int NC = 2;

    logic         clk;
    logic         reset_n;

    logic         start9, ready9, valid9, last9, busy9, done9;
    logic [511:0] mem9;
    logic [255:0] data9;
    logic [7:0]   idx9;

    logic         start8, ready8, valid8, last8, busy8, done8;
    logic [511:0] mem8;
    logic [255:0] data8;
    logic [7:0]   idx8;

    int compared;
    int mismatched;
    int unsigned ev[TOT];

    second_vector_vxv_reader #(.number_of_equations_per_cluster(9)) dut9 (
        .clk(clk), .reset_n(reset_n), .start(start9), .memory_output(mem9),
        .chunk_ready(ready9), .chunk_data(data9), .chunk_valid(valid9),
        .chunk_index(idx9), .last_chunk(last9), .busy(busy9), .done(done9)
    );

    second_vector_vxv_reader #(.number_of_equations_per_cluster(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .memory_output(mem8),
        .chunk_ready(ready8), .chunk_data(data8), .chunk_valid(valid8),
        .chunk_index(idx8), .last_chunk(last8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Vector word: element 0 first (MSB), then pad zeros up to TOT elements.
    function automatic logic [511:0] buildWord(input int n);
        logic [511:0] w = '0;
        for (int e = 0; e < TOT; e++) w = (w << W) | ((e < n) ? 512'(ev[e]) : 512'd0);
        return w;
    endfunction

    function automatic logic [255:0] modelChunk(input int n, input int k);
        logic [255:0] c = '0;
        for (int j = 0; j < U; j++) begin
            int e = k * U + j;
            c = (c << W) | ((e < n) ? 256'(ev[e]) : 256'd0);
        end
        return c;
    endfunction

    task automatic applyStimulus(input logic [15:0] readyPat, input bit pulseStart,
                                 input bit corruptMem, output int dataCycles);
        int idx;
        bit finished;
        for (int e = 0; e < TOT; e++) ev[e] = $urandom;
        mem9   = buildWord(9);
        start9 = 1'b1;
        @(negedge clk);
        start9 = pulseStart;
        if (corruptMem) mem9 = '1;
        idx = 0;
        finished = 1'b0;
        dataCycles = 0;
        for (int c = 0; c < 16 && !finished; c++) begin
            checkOutput("valid", valid9, 1);
            checkOutput("busy", busy9, 1);
            checkOutput("done_early", done9, 0);
            checkOutput("index", idx9, idx);
            checkOutput("last", last9, (idx == NC - 1));
            checkOutput("data", data9, modelChunk(9, idx));
            ready9 = readyPat[c];
            dataCycles++;
            @(negedge clk);
            if (readyPat[c]) begin
                if (idx == NC - 1) finished = 1'b1;
                else idx++;
            end
        end
        checkOutput("pass_finished", finished, 1);
        ready9 = 1'b0;
        checkOutput("fin_done", done9, 1);
        checkOutput("fin_valid", valid9, 0);
        checkOutput("fin_busy", busy9, 1);
        checkOutput("fin_last", last9, 0);
        @(negedge clk);
        start9 = 1'b0;
        checkOutput("idle_done", done9, 0);
        checkOutput("idle_busy", busy9, 0);
        checkOutput("idle_valid", valid9, 0);
    endtask

    initial begin
        int cyc;
        logic [15:0] pat;
        compared = 0;
        mismatched = 0;
        reset_n = 1'b0;
        start9 = 0; ready9 = 0; mem9 = '0;
        start8 = 0; ready8 = 0; mem8 = '0;
        #12;
        checkOutput("rst_valid", valid9, 0);
        checkOutput("rst_busy", busy9, 0);
        checkOutput("rst_done", done9, 0);
        checkOutput("rst_last", last9, 0);
        checkOutput("rst_index", idx9, 0);
        checkOutput("rst_data", data9, 0);
        checkOutput("rst8_valid", valid8, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'hFFFF, 1'b0, 1'b0, cyc);
        checkOutput("full_rate_cycles", cyc, 2);
        applyStimulus(16'hFFF8, 1'b0, 1'b0, cyc);
        checkOutput("stall3_cycles", cyc, 5);
        pat = 16'($urandom) | 16'hC000;
        applyStimulus(pat, 1'b0, 1'b1, cyc);
        applyStimulus(16'hFFFF, 1'b1, 1'b0, cyc);
        applyStimulus(16'hFFFF, 1'b0, 1'b0, cyc);

        // Abort while chunk 0 is on the bus.
        for (int e = 0; e < TOT; e++) ev[e] = $urandom;
        mem9 = buildWord(9);
        start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        checkOutput("abort_pre_valid", valid9, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_valid", valid9, 0);
        checkOutput("abort_busy", busy9, 0);
        checkOutput("abort_data", data9, 0);
        checkOutput("abort_done", done9, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_after_busy", busy9, 0);
        checkOutput("abort_after_done", done9, 0);
        applyStimulus(16'hFFFF, 1'b0, 1'b0, cyc);

        for (int p = 0; p < 6; p++) begin
            pat = 16'($urandom) | 16'hC000;
            applyStimulus(pat, 1'b0, p[0], cyc);
        end

        // Fully padded case: the second chunk is all zeros.
        for (int e = 0; e < TOT; e++) ev[e] = $urandom;
        mem8 = buildWord(8);
        start8 = 1'b1;
        ready8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("n8_c0_valid", valid8, 1);
        checkOutput("n8_c0_data", data8, modelChunk(8, 0));
        checkOutput("n8_c0_last", last8, 0);
        @(negedge clk);
        checkOutput("n8_c1_index", idx8, 1);
        checkOutput("n8_c1_data", data8, modelChunk(8, 1));
        checkOutput("n8_c1_last", last8, 1);
        @(negedge clk);
        ready8 = 1'b0;
        checkOutput("n8_done", done8, 1);
        checkOutput("n8_fin_valid", valid8, 0);
        @(negedge clk);
        checkOutput("n8_idle_busy", busy8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
